// File: rtl/trigger_seq_pkg.sv
// Shared types for the trigger sequencer: FSM state encoding
// and the default width of configuration/index fields.
package trigger_seq_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_BURST,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down counter that stops at 1 and never wraps.
// Ports: clk, reset (sync, active-high), load/load_val, dec, cnt, term.
module seq_down_counter
  import trigger_seq_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q > W'(1))) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  // Loaded values are always >= 1, so 1 marks the final cycle.
  assign term = (cnt_q <= W'(1));

endmodule

// File: rtl/trigger_sequencer.sv
// Burst trigger sequencer: delay, then N bursts of trigger-high
// separated by gaps. Ports: fastclk, reset, start, abort, cfg_*,
// trigger, busy, done, aborted, burst_idx. All outputs registered
// except busy, which decodes the state register.
module trigger_sequencer
  import trigger_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_burst_len,
  input  logic [CNT_W-1:0] cfg_gap_len,
  input  logic [CNT_W-1:0] cfg_burst_count,
  output logic             trigger,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] burst_idx
);

  function automatic logic [CNT_W-1:0] max1(
    input logic [CNT_W-1:0] v
  );
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             trig_q, trig_d;
  logic             done_q, done_d;
  logic             abrt_q, abrt_d;

  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             dec;
  logic [CNT_W-1:0] cnt;
  logic             term;

  seq_down_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk     (fastclk),
    .reset   (reset),
    .load    (ld),
    .load_val(ld_val),
    .dec     (dec),
    .cnt     (cnt),
    .term    (term)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    gap_d   = gap_q;
    bcnt_d  = bcnt_q;
    abrt_d  = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          len_d  = cfg_burst_len;
          gap_d  = cfg_gap_len;
          bcnt_d = cfg_burst_count;
          idx_d  = '0;
          if (cfg_burst_count == '0) begin
            state_d = ST_DONE;
          end else if (cfg_delay == '0) begin
            state_d = ST_BURST;
            ld      = 1'b1;
            ld_val  = max1(cfg_burst_len);
          end else begin
            state_d = ST_DELAY;
            ld      = 1'b1;
            ld_val  = cfg_delay;
          end
        end
      end
      ST_DELAY: begin
        if (abort) begin
          state_d = ST_IDLE;
          abrt_d  = 1'b1;
        end else if (term) begin
          state_d = ST_BURST;
          ld      = 1'b1;
          ld_val  = max1(len_q);
        end else begin
          dec = 1'b1;
        end
      end
      ST_BURST: begin
        if (abort) begin
          state_d = ST_IDLE;
          abrt_d  = 1'b1;
        end else if (term) begin
          if (idx_q == bcnt_q - CNT_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            ld      = 1'b1;
            ld_val  = max1(gap_q);
          end
        end else begin
          dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
          abrt_d  = 1'b1;
        end else if (term) begin
          state_d = ST_BURST;
          idx_d   = idx_q + CNT_W'(1);
          ld      = 1'b1;
          ld_val  = max1(len_q);
        end else begin
          dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Outputs follow the next state so they line up with it.
    trig_d = (state_d == ST_BURST);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      bcnt_q  <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      bcnt_q  <= bcnt_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
    end
  end

  assign trigger   = trig_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign aborted   = abrt_q;
  assign burst_idx = idx_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer.
// Outputs are sampled 1 time unit after each rising edge.
module tb_trigger_sequencer;

  logic       fastclk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] cfg_delay;
  logic [7:0] cfg_burst_len;
  logic [7:0] cfg_gap_len;
  logic [7:0] cfg_burst_count;
  logic       trigger;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] burst_idx;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 fastclk = ~fastclk;

  trigger_sequencer dut (
    .fastclk        (fastclk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .cfg_delay      (cfg_delay),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_gap_len    (cfg_gap_len),
    .cfg_burst_count(cfg_burst_count),
    .trigger        (trigger),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .burst_idx      (burst_idx)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge fastclk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return 32'({trigger, busy, done, aborted});
  endfunction

  // Drive cfg and a one-cycle start; returns with E1 values visible.
  task automatic begin_seq(
    input logic [7:0] d,
    input logic [7:0] l,
    input logic [7:0] g,
    input logic [7:0] c
  );
    cfg_delay       = d;
    cfg_burst_len   = l;
    cfg_gap_len     = g;
    cfg_burst_count = c;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Check E1..En against expected trigger/busy/done bit strings;
  // burst_idx expected 1 from cycle k1, 2 from cycle k2.
  task automatic run_cmp(
    input string       tag,
    input int          n,
    input logic [1:16] et,
    input logic [1:16] eb,
    input logic [1:16] ed,
    input int          k1,
    input int          k2
  );
    for (int k = 1; k <= n; k++) begin
      int ei;
      ei = (k >= k2) ? 2 : (k >= k1) ? 1 : 0;
      check($sformatf("%s_o_E%0d", tag, k), outs(),
            32'({et[k], eb[k], ed[k], 1'b0}));
      check($sformatf("%s_idx_E%0d", tag, k),
            32'(burst_idx), 32'(ei));
      step();
    end
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b1;
    abort           = 1'b1;
    cfg_delay       = 8'd0;
    cfg_burst_len   = 8'd3;
    cfg_gap_len     = 8'd0;
    cfg_burst_count = 8'd1;
    step();
    step();
    check("rst_outs", outs(), 32'h0);
    check("rst_idx", 32'(burst_idx), 32'h0);
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    step();
    check("post_rst", outs(), 32'h0);

    // delay=0 len=3 gap=2 count=2
    begin_seq(8'd0, 8'd3, 8'd2, 8'd2);
    run_cmp("seq1", 10,
            16'b1110011100_000000,
            16'b1111111110_000000,
            16'b0000000010_000000, 6, 99);

    // delay=4 len=1 gap=0 count=3
    begin_seq(8'd4, 8'd1, 8'd0, 8'd3);
    run_cmp("seq2", 11,
            16'b00001010100_00000,
            16'b11111111110_00000,
            16'b00000000010_00000, 7, 9);

    // count=0
    begin_seq(8'd3, 8'd3, 8'd1, 8'd0);
    run_cmp("cnt0", 3,
            16'b000_0000000000000,
            16'b100_0000000000000,
            16'b100_0000000000000, 99, 99);

    // abort in 2nd cycle of burst 1
    begin_seq(8'd0, 8'd5, 8'd1, 8'd3);
    for (int i = 0; i < 7; i++) step();
    check("abt_pre", outs(), 32'b1100);
    check("abt_pre_idx", 32'(burst_idx), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_edge", outs(), 32'b0001);
    check("abt_idx", 32'(burst_idx), 32'd1);
    step();
    check("abt_after", outs(), 32'b0000);
    check("abt_idx_hold", 32'(burst_idx), 32'd1);

    // reset mid-GAP
    begin_seq(8'd0, 8'd2, 8'd3, 8'd2);
    step();
    step();
    step();
    check("rg_pre", outs(), 32'b0100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rg_outs", outs(), 32'h0);
    check("rg_idx", 32'(burst_idx), 32'h0);

    // reset mid-BURST
    begin_seq(8'd0, 8'd4, 8'd1, 8'd1);
    step();
    check("rb_pre", outs(), 32'b1100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rb_edge", outs(), 32'h0);
    step();
    check("rb_after", outs(), 32'h0);

    // start while busy is ignored
    begin_seq(8'd0, 8'd3, 8'd1, 8'd1);
    step();
    start           = 1'b1;
    cfg_delay       = 8'd2;
    cfg_burst_count = 8'd3;
    step();
    start = 1'b0;
    check("sb_E3", outs(), 32'b1100);
    step();
    check("sb_done", outs(), 32'b0110);
    step();
    check("sb_idle", outs(), 32'h0);
    step();
    check("sb_idle2", outs(), 32'h0);

    // start+abort in IDLE
    cfg_delay       = 8'd0;
    cfg_burst_count = 8'd2;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_edge", outs(), 32'h0);
    step();
    check("sa_after", outs(), 32'h0);

    // burst_len changed mid-sequence
    begin_seq(8'd0, 8'd3, 8'd1, 8'd2);
    cfg_burst_len = 8'd7;
    run_cmp("lenchg", 9,
            16'b111011100_0000000,
            16'b111111110_0000000,
            16'b000000010_0000000, 5, 99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of all configuration and index fields.
REQ-002 Port fastclk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port start  input  1  SHALL request a sequence, sampled in IDLE only.
REQ-005 Port abort  input  1  SHALL terminate any sequence in progress.
REQ-006 Port cfg_delay  input  CNT_W  SHALL give the idle cycles between start and the first burst.
REQ-007 Port cfg_burst_len  input  CNT_W  SHALL give the trigger-high cycles per burst.
REQ-008 Port cfg_gap_len  input  CNT_W  SHALL give the trigger-low cycles between bursts.
REQ-009 Port cfg_burst_count  input  CNT_W  SHALL give the number of bursts per sequence.
REQ-010 Port trigger  output  1  SHALL drive the trigger input of the clock-gating block; registered.
REQ-011 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-012 Port done  output  1  SHALL pulse one cycle on normal completion.
REQ-013 Port aborted  output  1  SHALL pulse one cycle when a sequence is aborted.
REQ-014 Port burst_idx  output  CNT_W  SHALL give the zero-based index of the current or last burst.

Function
REQ-015 States SHALL be IDLE, DELAY, BURST, GAP, DONE.
REQ-016 IDLE with start=1 and abort=0 at edge E0 SHALL latch all cfg_* inputs; cfg_* changes after E0 SHALL not affect the running sequence.
REQ-017 From IDLE: cfg_burst_count=0 -> DONE; else cfg_delay=0 -> BURST; else -> DELAY.
REQ-018 DELAY SHALL last exactly cfg_delay cycles, then -> BURST.
REQ-019 BURST SHALL last max(cfg_burst_len,1) cycles; trigger SHALL be 1 exactly during BURST.
REQ-020 At end of BURST: if burst_idx = cfg_burst_count-1 -> DONE, else -> GAP.
REQ-021 GAP SHALL last max(cfg_gap_len,1) cycles, then burst_idx increments by 1 and -> BURST; a zero gap never merges bursts.
REQ-022 DONE SHALL last one cycle with done=1, then -> IDLE.
REQ-023 With cfg_delay=0, trigger SHALL rise at E1, giving one cycle of start-to-trigger latency.
REQ-024 start while busy=1 SHALL be ignored.
REQ-025 abort=1 in DELAY/BURST/GAP SHALL force IDLE at the next edge, with trigger=0, aborted=1 for one cycle and done=0.
REQ-026 abort and start together in IDLE SHALL be ignored, with no aborted pulse; abort in DONE SHALL not suppress done.
REQ-027 burst_idx SHALL clear to 0 on sequence start and hold its value in IDLE.
REQ-028 Cycle counters SHALL be CNT_W wide, count down to 1, and never wrap.

Reset
REQ-029 reset=1 at any edge SHALL force IDLE, overriding start and abort.
REQ-030 Under reset, trigger, busy, done and aborted SHALL be 0, and burst_idx and the counters SHALL be 0.
REQ-031 Reset mid-BURST SHALL drop trigger at that same edge without asserting done or aborted.

Structure
REQ-032 The state encoding and the CNT_W default SHALL live in shared package trigger_seq_pkg.
REQ-033 One sub-module, seq_down_counter, SHALL provide load, decrement and a terminal flag, and SHALL serve both DELAY/BURST/GAP timing.
REQ-034 The block SHALL contain no combinational path from any input to trigger.

Verification
REQ-035 delay=0, len=3, gap=2, count=2, start at E0 -> trigger high E1-E3, low E4-E5, high E6-E8; done at E9; busy low from E10.
REQ-036 delay=4, len=1, gap=0, count=3 -> first trigger at E5; three one-cycle pulses, each separated by one low cycle; burst_idx steps 0,1,2.
REQ-037 count=0 -> trigger stays 0; done at E1; busy high only at E1.
REQ-038 abort during the 2nd cycle of burst 1 (len=5) -> trigger 0 and aborted=1 at the next edge; done stays 0; burst_idx holds 1.
REQ-039 reset asserted mid-GAP, then start while busy, then start+abort in IDLE -> all outputs 0 after reset; both starts produce no sequence.
REQ-040 cfg_burst_len changed from 3 to 7 during a running sequence -> all bursts keep length 3.
